id_ex_stage: RTL and testbench



---
 rtl/rv32i_pkg.sv | 54 +++++
 rtl/hazard_detect.sv | 28 ++
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings and the decoded control bundle.
package rv32i_pkg;

  // ALU operation select
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  // Write-back result source
  localparam logic [1:0] RES_SRC_Alu = 2'b00;
  localparam logic [1:0] RES_SRC_Mem = 2'b01;
  localparam logic [1:0] RES_SRC_Pc4 = 2'b10;
  localparam logic [1:0] RES_SRC_Imm = 2'b11;

  // Immediate format
  localparam logic [2:0] IMM_SRC_I = 3'b000;
  localparam logic [2:0] IMM_SRC_S = 3'b001;
  localparam logic [2:0] IMM_SRC_B = 3'b010;
  localparam logic [2:0] IMM_SRC_J = 3'b011;
  localparam logic [2:0] IMM_SRC_U = 3'b100;

  // Load width / sign (funct3 encoding)
  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  // Store width
  localparam logic [1:0] STORE_SB = 2'b00;
  localparam logic [1:0] STORE_SH = 2'b01;
  localparam logic [1:0] STORE_SW = 2'b10;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       branch_on_not_equal;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic [1:0] store_type;
    logic [2:0] load_type;
  } ctrl_bundle_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection plus IF/ID stall and flush generation.
module hazard_detect
  import rv32i_pkg::*;
(
  input  logic       valid_e,
  input  logic       valid_d,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_e,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       stall_e,
  input  logic       pc_src_e,
  output logic       lw_hazard_o,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d
);

  // Conservative: rs fields are compared even for formats that do not read them.
  always_comb begin
    lw_hazard_o = valid_e & valid_d & (result_src_e == RES_SRC_Mem) & (rd_e != 5'd0) &
                  ((rs1_d == rd_e) | (rs2_d == rd_e));
    stall_f     = stall_e | lw_hazard_o;
    stall_d     = stall_e | lw_hazard_o;
    flush_d     = pc_src_e & ~stall_e;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and branch squash.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_d,
  input  logic             Reg_write_d,
  input  logic             Mem_Write_d,
  input  logic             jump_d,
  input  logic             Branch_d,
  input  logic             Alu_src_d,
  input  logic             branch_on_not_equal_d,
  input  logic [1:0]       Result_src_d,
  input  logic [3:0]       ALU_Control_d,
  input  logic [1:0]       Store_type_d,
  input  logic [2:0]       Load_type_d,
  input  logic [XLEN-1:0]  rd1_d,
  input  logic [XLEN-1:0]  rd2_d,
  input  logic [XLEN-1:0]  imm_ext_d,
  input  logic [XLEN-1:0]  pc_d,
  input  logic [XLEN-1:0]  pc_plus4_d,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  input  logic             stall_e,
  input  logic             pc_src_e,
  output logic             valid_e,
  output logic             Reg_write_e,
  output logic             Mem_Write_e,
  output logic             jump_e,
  output logic             Branch_e,
  output logic             Alu_src_e,
  output logic             branch_on_not_equal_e,
  output logic [1:0]       Result_src_e,
  output logic [3:0]       ALU_Control_e,
  output logic [1:0]       Store_type_e,
  output logic [2:0]       Load_type_e,
  output logic [XLEN-1:0]  rd1_e,
  output logic [XLEN-1:0]  rd2_e,
  output logic [XLEN-1:0]  imm_ext_e,
  output logic [XLEN-1:0]  pc_e,
  output logic [XLEN-1:0]  pc_plus4_e,
  output logic [4:0]       rs1_e,
  output logic [4:0]       rs2_e,
  output logic [4:0]       rd_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic [CNT_W-1:0] bubble_count
);

  ctrl_bundle_t ctrl_in, ctrl_d, ctrl_q;
  logic            valid_q_d, valid_q;
  logic [XLEN-1:0] rd1_q_d, rd1_q, rd2_q_d, rd2_q, imm_q_d, imm_q;
  logic [XLEN-1:0] pc_q_d, pc_q, pc4_q_d, pc4_q;
  logic [4:0]      rs1_q_d, rs1_q, rs2_q_d, rs2_q, rd_q_d, rd_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic            lw_hazard;

  // Gather the decoded control inputs into one bundle.
  always_comb begin
    ctrl_in.reg_write           = Reg_write_d;
    ctrl_in.mem_write           = Mem_Write_d;
    ctrl_in.jump                = jump_d;
    ctrl_in.branch              = Branch_d;
    ctrl_in.alu_src             = Alu_src_d;
    ctrl_in.branch_on_not_equal = branch_on_not_equal_d;
    ctrl_in.result_src          = Result_src_d;
    ctrl_in.alu_control         = ALU_Control_d;
    ctrl_in.store_type          = Store_type_d;
    ctrl_in.load_type           = Load_type_d;
  end

  hazard_detect u_hazard_detect (
    .valid_e      (valid_q),
    .valid_d      (valid_d),
    .result_src_e (ctrl_q.result_src),
    .rd_e         (rd_q),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .stall_e      (stall_e),
    .pc_src_e     (pc_src_e),
    .lw_hazard_o  (lw_hazard),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_d      (flush_d)
  );

  // Next-state: hold on downstream stall, bubble on squash or load-use, else load.
  always_comb begin
    ctrl_d    = ctrl_q;
    valid_q_d = valid_q;
    rd1_q_d   = rd1_q;
    rd2_q_d   = rd2_q;
    imm_q_d   = imm_q;
    pc_q_d    = pc_q;
    pc4_q_d   = pc4_q;
    rs1_q_d   = rs1_q;
    rs2_q_d   = rs2_q;
    rd_q_d    = rd_q;
    cnt_d     = cnt_q;
    if (stall_e) begin
      // keep everything
    end else if (pc_src_e || lw_hazard) begin
      ctrl_d    = '0;
      valid_q_d = 1'b0;
      rd1_q_d   = '0;
      rd2_q_d   = '0;
      imm_q_d   = '0;
      pc_q_d    = '0;
      pc4_q_d   = '0;
      rs1_q_d   = '0;
      rs2_q_d   = '0;
      rd_q_d    = '0;
      // Only load-use bubbles are counted, not branch squashes.
      if (!pc_src_e) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ctrl_d    = ctrl_in;
      valid_q_d = valid_d;
      rd1_q_d   = rd1_d;
      rd2_q_d   = rd2_d;
      imm_q_d   = imm_ext_d;
      pc_q_d    = pc_d;
      pc4_q_d   = pc_plus4_d;
      rs1_q_d   = rs1_d;
      rs2_q_d   = rs2_d;
      rd_q_d    = rd_d;
    end
  end

  // EX register and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_q_d;
      rd1_q   <= rd1_q_d;
      rd2_q   <= rd2_q_d;
      imm_q   <= imm_q_d;
      pc_q    <= pc_q_d;
      pc4_q   <= pc4_q_d;
      rs1_q   <= rs1_q_d;
      rs2_q   <= rs2_q_d;
      rd_q    <= rd_q_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drive the EX-side outputs from the register.
  always_comb begin
    valid_e               = valid_q;
    Reg_write_e           = ctrl_q.reg_write;
    Mem_Write_e           = ctrl_q.mem_write;
    jump_e                = ctrl_q.jump;
    Branch_e              = ctrl_q.branch;
    Alu_src_e             = ctrl_q.alu_src;
    branch_on_not_equal_e = ctrl_q.branch_on_not_equal;
    Result_src_e          = ctrl_q.result_src;
    ALU_Control_e         = ctrl_q.alu_control;
    Store_type_e          = ctrl_q.store_type;
    Load_type_e           = ctrl_q.load_type;
    rd1_e                 = rd1_q;
    rd2_e                 = rd2_q;
    imm_ext_e             = imm_q;
    pc_e                  = pc_q;
    pc_plus4_e            = pc4_q;
    rs1_e                 = rs1_q;
    rs2_e                 = rs2_q;
    rd_e                  = rd_q;
    bubble_count          = cnt_q;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (32-bit and 4-bit bubble counters).
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_d, Reg_write_d, Mem_Write_d, jump_d, Branch_d, Alu_src_d, bne_d;
  logic [1:0]  Result_src_d, Store_type_d;
  logic [3:0]  ALU_Control_d;
  logic [2:0]  Load_type_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        stall_e, pc_src_e;

  logic        valid_e, Reg_write_e, Mem_Write_e, jump_e, Branch_e, Alu_src_e, bne_e;
  logic [1:0]  Result_src_e, Store_type_e;
  logic [3:0]  ALU_Control_e;
  logic [2:0]  Load_type_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        stall_f, stall_d, flush_d;
  logic [31:0] bubble_count;

  logic        w_valid_e, w_Reg_write_e, w_Mem_Write_e, w_jump_e, w_Branch_e, w_Alu_src_e;
  logic        w_bne_e;
  logic [1:0]  w_Result_src_e, w_Store_type_e;
  logic [3:0]  w_ALU_Control_e;
  logic [2:0]  w_Load_type_e;
  logic [31:0] w_rd1_e, w_rd2_e, w_imm_ext_e, w_pc_e, w_pc_plus4_e;
  logic [4:0]  w_rs1_e, w_rs2_e, w_rd_e;
  logic        w_stall_f, w_stall_d, w_flush_d;
  logic [3:0]  w_bubble_count;

  logic [192:0] all_e, all4_e;
  assign all_e  = {valid_e, Reg_write_e, Mem_Write_e, jump_e, Branch_e, Alu_src_e, bne_e,
                   Result_src_e, ALU_Control_e, Store_type_e, Load_type_e, rd1_e, rd2_e,
                   imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e};
  assign all4_e = {w_valid_e, w_Reg_write_e, w_Mem_Write_e, w_jump_e, w_Branch_e,
                   w_Alu_src_e, w_bne_e, w_Result_src_e, w_ALU_Control_e, w_Store_type_e,
                   w_Load_type_e, w_rd1_e, w_rd2_e, w_imm_ext_e, w_pc_e, w_pc_plus4_e,
                   w_rs1_e, w_rs2_e, w_rd_e};

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .Reg_write_d(Reg_write_d),
    .Mem_Write_d(Mem_Write_d), .jump_d(jump_d), .Branch_d(Branch_d), .Alu_src_d(Alu_src_d),
    .branch_on_not_equal_d(bne_d), .Result_src_d(Result_src_d),
    .ALU_Control_d(ALU_Control_d), .Store_type_d(Store_type_d), .Load_type_d(Load_type_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .stall_e(stall_e), .pc_src_e(pc_src_e), .valid_e(valid_e), .Reg_write_e(Reg_write_e),
    .Mem_Write_e(Mem_Write_e), .jump_e(jump_e), .Branch_e(Branch_e),
    .Alu_src_e(Alu_src_e), .branch_on_not_equal_e(bne_e), .Result_src_e(Result_src_e),
    .ALU_Control_e(ALU_Control_e), .Store_type_e(Store_type_e),
    .Load_type_e(Load_type_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .Reg_write_d(Reg_write_d),
    .Mem_Write_d(Mem_Write_d), .jump_d(jump_d), .Branch_d(Branch_d), .Alu_src_d(Alu_src_d),
    .branch_on_not_equal_d(bne_d), .Result_src_d(Result_src_d),
    .ALU_Control_d(ALU_Control_d), .Store_type_d(Store_type_d), .Load_type_d(Load_type_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .stall_e(stall_e), .pc_src_e(pc_src_e), .valid_e(w_valid_e),
    .Reg_write_e(w_Reg_write_e), .Mem_Write_e(w_Mem_Write_e), .jump_e(w_jump_e),
    .Branch_e(w_Branch_e), .Alu_src_e(w_Alu_src_e), .branch_on_not_equal_e(w_bne_e),
    .Result_src_e(w_Result_src_e), .ALU_Control_e(w_ALU_Control_e),
    .Store_type_e(w_Store_type_e), .Load_type_e(w_Load_type_e), .rd1_e(w_rd1_e),
    .rd2_e(w_rd2_e), .imm_ext_e(w_imm_ext_e), .pc_e(w_pc_e), .pc_plus4_e(w_pc_plus4_e),
    .rs1_e(w_rs1_e), .rs2_e(w_rs2_e), .rd_e(w_rd_e), .stall_f(w_stall_f),
    .stall_d(w_stall_d), .flush_d(w_flush_d), .bubble_count(w_bubble_count)
  );

  // A load-use hazard and a taken branch must never coincide.
  always @(negedge clk) begin
    if (rst_n && stall_d && !stall_e && pc_src_e) begin
      failed++;
      $display("FAIL mutex: lw_hazard and pc_src_e both high at %0t", $time);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID-slot instruction; operand values derive from base.
  task automatic drive_d(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [1:0] rsrc, input logic [3:0] alu,
                         input logic regw, input logic br, input logic [31:0] base);
    valid_d       = v;
    rs1_d         = rs1;
    rs2_d         = rs2;
    rd_d          = rd;
    Result_src_d  = rsrc;
    ALU_Control_d = alu;
    Reg_write_d   = regw;
    Branch_d      = br;
    Mem_Write_d   = 1'b0;
    jump_d        = 1'b0;
    bne_d         = 1'b0;
    Alu_src_d     = (rsrc == 2'b01);
    Store_type_d  = 2'b00;
    Load_type_d   = (rsrc == 2'b01) ? 3'b010 : 3'b000;
    rd1_d         = base;
    rd2_d         = base + 32'd1;
    imm_ext_d     = base + 32'd2;
    pc_d          = base + 32'h100;
    pc_plus4_d    = base + 32'h104;
  endtask

  task automatic test_reset();
    drive_d(1'b1, 5'd1, 5'd2, 5'd5, 2'b01, 4'b0000, 1'b1, 1'b0, 32'h50);
    step();
    drive_d(1'b1, 5'd5, 5'd2, 5'd6, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h60);
    #1;
    tests++; if (stall_d !== 1'b1) begin failed++;
      $display("FAIL rst_pre_hazard: stall_d=%b want 1", stall_d); end
    rst_n = 1'b0;
    #1;
    tests++; if (all_e !== '0) begin failed++;
      $display("FAIL rst_async_e: got %h want 0", all_e); end
    tests++; if (bubble_count !== 32'd0) begin failed++;
      $display("FAIL rst_async_cnt: got %0d want 0", bubble_count); end
    tests++; if ({stall_f, stall_d, flush_d} !== 3'b000) begin failed++;
      $display("FAIL rst_async_stall: got %b want 000", {stall_f, stall_d, flush_d}); end
    #2;
    rst_n = 1'b1;
    step();
    tests++; if ({valid_e, rd_e, rd1_e} !== {1'b1, 5'd6, 32'h60}) begin failed++;
      $display("FAIL rst_first_load: valid=%b rd=%0d rd1=%h want 1 6 60", valid_e, rd_e,
               rd1_e); end
    tests++; if (bubble_count !== 32'd0) begin failed++;
      $display("FAIL rst_no_bubble: got %0d want 0", bubble_count); end
  endtask

  task automatic test_pass_through();
    drive_d(1'b1, 5'd1, 5'd2, 5'd3, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h30);
    #1;
    tests++; if ({stall_f, stall_d} !== 2'b00) begin failed++;
      $display("FAIL pt_stall_pre: got %b want 00", {stall_f, stall_d}); end
    step();
    tests++; if ({ALU_Control_e, rd_e, valid_e, Reg_write_e} !== {4'b0000, 5'd3, 1'b1, 1'b1})
    begin failed++;
      $display("FAIL pt_add: alu=%b rd=%0d valid=%b regw=%b want 0000 3 1 1", ALU_Control_e,
               rd_e, valid_e, Reg_write_e); end
    tests++; if ({rd1_e, rs1_e, rs2_e} !== {32'h30, 5'd1, 5'd2}) begin failed++;
      $display("FAIL pt_ops: rd1=%h rs1=%0d rs2=%0d want 30 1 2", rd1_e, rs1_e, rs2_e); end
    tests++; if ({stall_f, stall_d} !== 2'b00) begin failed++;
      $display("FAIL pt_stall_post: got %b want 00", {stall_f, stall_d}); end
    drive_d(1'b1, 5'd3, 5'd4, 5'd4, 2'b00, 4'b1000, 1'b1, 1'b0, 32'h40);
    step();
    tests++; if ({ALU_Control_e, imm_ext_e, pc_plus4_e, rd2_e} !==
                 {4'b1000, 32'h42, 32'h144, 32'h41}) begin failed++;
      $display("FAIL pt_sub: alu=%b imm=%h pc4=%h rd2=%h want 1000 42 144 41", ALU_Control_e,
               imm_ext_e, pc_plus4_e, rd2_e); end
  endtask

  task automatic test_load_use();
    // rs1 match
    drive_d(1'b1, 5'd4, 5'd0, 5'd5, 2'b01, 4'b0000, 1'b1, 1'b0, 32'h50);
    step();
    drive_d(1'b1, 5'd5, 5'd2, 5'd6, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h70);
    #1;
    tests++; if ({stall_f, stall_d, flush_d} !== 3'b110) begin failed++;
      $display("FAIL lu_stall: got %b want 110", {stall_f, stall_d, flush_d}); end
    step();
    tests++; if ({valid_e, Reg_write_e, rd_e} !== {1'b0, 1'b0, 5'd0}) begin failed++;
      $display("FAIL lu_bubble: valid=%b regw=%b rd=%0d want 0 0 0", valid_e, Reg_write_e,
               rd_e); end
    tests++; if (bubble_count !== 32'd1) begin failed++;
      $display("FAIL lu_count: got %0d want 1", bubble_count); end
    tests++; if (stall_d !== 1'b0) begin failed++;
      $display("FAIL lu_clear: stall_d=%b want 0", stall_d); end
    step();
    tests++; if ({valid_e, rd_e, rd1_e} !== {1'b1, 5'd6, 32'h70}) begin failed++;
      $display("FAIL lu_late: valid=%b rd=%0d rd1=%h want 1 6 70", valid_e, rd_e, rd1_e); end
    // rs2 match
    drive_d(1'b1, 5'd1, 5'd0, 5'd7, 2'b01, 4'b0000, 1'b1, 1'b0, 32'h54);
    step();
    drive_d(1'b1, 5'd1, 5'd7, 5'd8, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h74);
    #1;
    tests++; if (stall_d !== 1'b1) begin failed++;
      $display("FAIL lu_rs2_stall: got %b want 1", stall_d); end
    step();
    step();
    tests++; if ({rd_e, bubble_count} !== {5'd8, 32'd2}) begin failed++;
      $display("FAIL lu_rs2_late: rd=%0d cnt=%0d want 8 2", rd_e, bubble_count); end
    // rd = x0 never stalls
    drive_d(1'b1, 5'd1, 5'd0, 5'd0, 2'b01, 4'b0000, 1'b1, 1'b0, 32'h58);
    step();
    drive_d(1'b1, 5'd0, 5'd0, 5'd9, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h78);
    #1;
    tests++; if (stall_d !== 1'b0) begin failed++;
      $display("FAIL lu_x0_stall: got %b want 0", stall_d); end
    step();
    tests++; if ({valid_e, rd_e, bubble_count} !== {1'b1, 5'd9, 32'd2}) begin failed++;
      $display("FAIL lu_x0_load: valid=%b rd=%0d cnt=%0d want 1 9 2", valid_e, rd_e,
               bubble_count); end
  endtask

  task automatic test_branch();
    drive_d(1'b1, 5'd1, 5'd2, 5'd0, 2'b00, 4'b1000, 1'b0, 1'b1, 32'h80);
    step();
    pc_src_e = 1'b1;
    drive_d(1'b1, 5'd1, 5'd2, 5'd10, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h90);
    #1;
    tests++; if ({flush_d, stall_d} !== 2'b10) begin failed++;
      $display("FAIL br_flush: flush/stall=%b want 10", {flush_d, stall_d}); end
    step();
    pc_src_e = 1'b0;
    #1;
    tests++; if ({valid_e, Branch_e, rd_e, flush_d} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
      failed++;
      $display("FAIL br_squash: valid=%b br=%b rd=%0d flush=%b want 0 0 0 0", valid_e,
               Branch_e, rd_e, flush_d); end
  endtask

  task automatic test_downstream_stall();
    drive_d(1'b1, 5'd1, 5'd2, 5'd11, 2'b00, 4'b0101, 1'b1, 1'b1, 32'hA0);
    step();
    stall_e  = 1'b1;
    pc_src_e = 1'b1;
    drive_d(1'b1, 5'd1, 5'd2, 5'd12, 2'b00, 4'b0000, 1'b1, 1'b0, 32'hB0);
    #1;
    tests++; if ({flush_d, stall_f, stall_d} !== 3'b011) begin failed++;
      $display("FAIL ds_flush_held: got %b want 011", {flush_d, stall_f, stall_d}); end
    for (int i = 0; i < 3; i++) begin
      step();
      pc_src_e = 1'b0;
      #1;
      tests++; if ({valid_e, rd_e, ALU_Control_e, rd1_e, flush_d} !==
                   {1'b1, 5'd11, 4'b0101, 32'hA0, 1'b0}) begin failed++;
        $display("FAIL ds_frozen%0d: valid=%b rd=%0d alu=%b rd1=%h flush=%b", i, valid_e, rd_e,
                 ALU_Control_e, rd1_e, flush_d); end
    end
    stall_e  = 1'b0;
    pc_src_e = 1'b1;
    #1;
    tests++; if ({flush_d, stall_d} !== 2'b10) begin failed++;
      $display("FAIL ds_release_flush: got %b want 10", {flush_d, stall_d}); end
    step();
    pc_src_e = 1'b0;
    tests++; if ({valid_e, rd_e, bubble_count} !== {1'b0, 5'd0, 32'd2}) begin failed++;
      $display("FAIL ds_squash: valid=%b rd=%0d cnt=%0d want 0 0 2", valid_e, rd_e,
               bubble_count); end
  endtask

  task automatic test_stall_hazard();
    drive_d(1'b1, 5'd1, 5'd0, 5'd13, 2'b01, 4'b0000, 1'b1, 1'b0, 32'hC0);
    step();
    drive_d(1'b1, 5'd13, 5'd0, 5'd14, 2'b00, 4'b0000, 1'b1, 1'b0, 32'hD0);
    stall_e = 1'b1;
    step();
    tests++; if ({rd_e, Result_src_e, bubble_count} !== {5'd13, 2'b01, 32'd2}) begin failed++;
      $display("FAIL sh_hold: rd=%0d rsrc=%b cnt=%0d want 13 01 2", rd_e, Result_src_e,
               bubble_count); end
    stall_e = 1'b0;
    step();
    tests++; if ({valid_e, bubble_count} !== {1'b0, 32'd3}) begin failed++;
      $display("FAIL sh_bubble: valid=%b cnt=%0d want 0 3", valid_e, bubble_count); end
    step();
    tests++; if (rd_e !== 5'd14) begin failed++;
      $display("FAIL sh_late: rd=%0d want 14", rd_e); end
  endtask

  task automatic test_counter_wrap();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_d(1'b1, 5'd1, 5'd2, 5'd5, 2'b01, 4'b0000, 1'b1, 1'b0, 32'h200);
      step();
      drive_d(1'b1, 5'd5, 5'd2, 5'd6, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h300);
      step();
      if (i == 14) begin
        tests++; if (w_bubble_count !== 4'd15) begin failed++;
          $display("FAIL wrap_15: got %0d want 15", w_bubble_count); end
      end
    end
    tests++; if (w_bubble_count !== 4'd0) begin failed++;
      $display("FAIL wrap_0: got %0d want 0", w_bubble_count); end
    tests++; if (bubble_count !== 32'd16) begin failed++;
      $display("FAIL wrap_wide: got %0d want 16", bubble_count); end
    tests++; if ({all4_e, w_stall_f, w_stall_d, w_flush_d} !== '0) begin failed++;
      $display("FAIL wrap_bubble4: e=%h stalls=%b want 0", all4_e,
               {w_stall_f, w_stall_d, w_flush_d}); end
  endtask

  initial begin
    rst_n    = 1'b0;
    stall_e  = 1'b0;
    pc_src_e = 1'b0;
    drive_d(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 4'b0000, 1'b0, 1'b0, 32'h0);
    step();
    step();
    tests++; if (all_e !== '0 || bubble_count !== 32'd0) begin failed++;
      $display("FAIL reset_state: e=%h cnt=%0d want 0", all_e, bubble_count); end
    rst_n = 1'b1;
    test_reset();
    test_pass_through();
    test_load_use();
    test_branch();
    test_downstream_stall();
    test_stall_hazard();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
